// File: rtl/pulse_id_pkg.sv
// Shared definitions for the multi-sensor pulse identifier: default widths,
// controller state encoding and the timeout timer width helper.
package pulse_id_pkg;

    localparam int DATA_W_DEF = 17;
    localparam int TS_W_DEF   = 24;

    typedef enum logic [2:0] {
        IDLE        = 3'd0,
        WAIT_SECOND = 3'd1,
        POLY_REQ    = 3'd2,
        POLY_WAIT   = 3'd3,
        OFFS_REQ    = 3'd4,
        OFFS_WAIT   = 3'd5,
        READY       = 3'd6,
        FLUSH       = 3'd7
    } state_t;

    // The timer only has to hold values up to ticks-1.
    function automatic int timer_width(input int ticks);
        return (ticks > 2) ? $clog2(ticks) : 1;
    endfunction

endpackage

// File: rtl/multi_pulse_identifier_arbiter.sv
// Combinational lowest-index arbiter over the unmasked decoder channels.
module channel_arbiter
    import pulse_id_pkg::*;
#(
    parameter int NUM_SENSORS = 4,
    parameter int IDX_W       = 2
) (
    input  logic [NUM_SENSORS-1:0] request,
    input  logic [NUM_SENSORS-1:0] mask,
    output logic [IDX_W-1:0]       index,
    output logic                   found
);

    // Scanning downwards lets the lowest eligible channel overwrite the result last.
    always_comb begin
        index = '0;
        found = 1'b0;
        for (int i = NUM_SENSORS - 1; i >= 0; i--) begin
            if (request[i] && !mask[i]) begin
                index = IDX_W'(i);
                found = 1'b1;
            end
        end
    end

endmodule

// File: rtl/multi_pulse_identifier.sv
// Pairs the first two decoded LFSR words from distinct sensors, runs the external
// polynomial/offset finders and publishes per-sensor pulse IDs.
// Optional saturating error counter: define PULSE_ID_ERRCNT_EN.
module multi_pulse_identifier
    import pulse_id_pkg::*;
#(
    parameter int NUM_SENSORS   = 4,
    parameter int TIMEOUT_TICKS = 100000,
    parameter int DATA_W        = DATA_W_DEF,
    parameter int TS_W          = TS_W_DEF
) (
    input  logic                          clk_96MHz,
    input  logic                          reset_n,
    input  logic [NUM_SENSORS-1:0]        data_available,
    input  logic [NUM_SENSORS*TS_W-1:0]   ts_data,
    input  logic [NUM_SENSORS*DATA_W-1:0] decoded_data,
    output logic [NUM_SENSORS-1:0]        decoder_clear,
    output logic                          poly_start,
    output logic [DATA_W-1:0]             poly_first_data,
    output logic [DATA_W-1:0]             poly_second_data,
    output logic [TS_W-1:0]               poly_first_ts,
    output logic [TS_W-1:0]               poly_second_ts,
    input  logic                          poly_done,
    input  logic [DATA_W-1:0]             poly_polynomial,
    input  logic [DATA_W-1:0]             poly_iteration,
    output logic                          offs_start,
    input  logic                          offs_done,
    input  logic [DATA_W-1:0]             offs_offset,
    output logic [DATA_W-1:0]             polynomial,
    output logic [NUM_SENSORS*DATA_W-1:0] pulse_id,
    output logic [NUM_SENSORS-1:0]        pulse_valid,
    output logic                          ready,
    input  logic                          ack,
    output logic [7:0]                    error_count
);

    localparam int IDX_W = $clog2(NUM_SENSORS);
    localparam int TMR_W = timer_width(TIMEOUT_TICKS);
    localparam logic [TMR_W-1:0] TIMER_LAST = TMR_W'(TIMEOUT_TICKS - 1);

    state_t                  state, next_state;
    logic [TMR_W-1:0]        timer;
    logic [IDX_W-1:0]        first_ch, second_ch;
    logic [NUM_SENSORS-1:0]  captured;
    logic [NUM_SENSORS-1:0]  clear_reg;
    logic [DATA_W-1:0]       iteration;
    logic [DATA_W-1:0]       id_q [NUM_SENSORS];
    logic [DATA_W-1:0]       word_in [NUM_SENSORS];
    logic [TS_W-1:0]         ts_in [NUM_SENSORS];
    logic [IDX_W-1:0]        pick_idx;
    logic                    pick_found;
    logic [NUM_SENSORS-1:0]  pick_onehot;
    logic                    timeout_hit;

    always_comb begin
        pulse_id = '0;
        for (int i = 0; i < NUM_SENSORS; i++) begin
            word_in[i] = decoded_data[i*DATA_W +: DATA_W];
            ts_in[i]   = ts_data[i*TS_W +: TS_W];
            pulse_id[i*DATA_W +: DATA_W] = id_q[i];
        end
    end

    // Captured channels and those whose clear is in flight are not eligible as second.
    channel_arbiter #(
        .NUM_SENSORS (NUM_SENSORS),
        .IDX_W       (IDX_W)
    ) u_arbiter (
        .request (data_available),
        .mask    (captured | clear_reg),
        .index   (pick_idx),
        .found   (pick_found)
    );

    assign pick_onehot = NUM_SENSORS'(1) << pick_idx;
    assign timeout_hit = (timer == TIMER_LAST);

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) state <= IDLE;
        else          state <= next_state;
    end

    always_comb begin
        next_state = state;
        case (state)
            IDLE:        if (pick_found) next_state = WAIT_SECOND;
            WAIT_SECOND: begin
                if (pick_found)       next_state = POLY_REQ;
                else if (timeout_hit) next_state = FLUSH;
            end
            POLY_REQ:    next_state = POLY_WAIT;
            POLY_WAIT:   if (poly_done) next_state = (poly_polynomial == '0) ? FLUSH : OFFS_REQ;
            OFFS_REQ:    next_state = OFFS_WAIT;
            OFFS_WAIT:   if (offs_done) next_state = (offs_offset == '0) ? FLUSH : READY;
            READY:       if (ack) next_state = FLUSH;
            FLUSH:       next_state = IDLE;
            default:     next_state = IDLE;
        endcase
    end

    // FLUSH drains whatever arrived meanwhile; captured channels were cleared already.
    always_comb begin
        poly_start    = (state == POLY_REQ) || (state == POLY_WAIT);
        offs_start    = (state == OFFS_REQ) || (state == OFFS_WAIT);
        ready         = (state == READY);
        decoder_clear = clear_reg;
        if (state == FLUSH) decoder_clear = clear_reg | (data_available & ~captured);
    end

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n) begin
            timer            <= '0;
            first_ch         <= '0;
            second_ch        <= '0;
            captured         <= '0;
            clear_reg        <= '0;
            iteration        <= '0;
            polynomial       <= '0;
            pulse_valid      <= '0;
            poly_first_data  <= '0;
            poly_second_data <= '0;
            poly_first_ts    <= '0;
            poly_second_ts   <= '0;
            for (int i = 0; i < NUM_SENSORS; i++) id_q[i] <= '0;
        end else begin
            clear_reg <= '0;
            case (state)
                IDLE: begin
                    if (pick_found) begin
                        poly_first_data <= word_in[pick_idx];
                        poly_first_ts   <= ts_in[pick_idx];
                        first_ch        <= pick_idx;
                        captured        <= pick_onehot;
                        clear_reg       <= pick_onehot;
                        timer           <= '0;
                    end
                end
                WAIT_SECOND: begin
                    if (pick_found) begin
                        poly_second_data <= word_in[pick_idx];
                        poly_second_ts   <= ts_in[pick_idx];
                        second_ch        <= pick_idx;
                        captured         <= captured | pick_onehot;
                        clear_reg        <= pick_onehot;
                    end else if (!timeout_hit) begin
                        timer <= timer + 1'b1;
                    end
                end
                POLY_WAIT: begin
                    if (poly_done && (poly_polynomial != '0)) begin
                        polynomial <= poly_polynomial;
                        iteration  <= poly_iteration;
                    end
                end
                OFFS_WAIT: begin
                    if (offs_done && (offs_offset != '0)) begin
                        for (int i = 0; i < NUM_SENSORS; i++) begin
                            if (IDX_W'(i) == first_ch)       id_q[i] <= offs_offset;
                            else if (IDX_W'(i) == second_ch) id_q[i] <= offs_offset + iteration;
                            else                             id_q[i] <= '0;
                        end
                        pulse_valid <= captured;
                    end
                end
                FLUSH: begin
                    timer            <= '0;
                    first_ch         <= '0;
                    second_ch        <= '0;
                    captured         <= '0;
                    iteration        <= '0;
                    polynomial       <= '0;
                    pulse_valid      <= '0;
                    poly_first_data  <= '0;
                    poly_second_data <= '0;
                    poly_first_ts    <= '0;
                    poly_second_ts   <= '0;
                    for (int i = 0; i < NUM_SENSORS; i++) id_q[i] <= '0;
                end
                default: ;
            endcase
        end
    end

`ifdef PULSE_ID_ERRCNT_EN
    function automatic logic [7:0] sat_inc(input logic [7:0] value);
        return (value == 8'hFF) ? value : value + 8'd1;
    endfunction

    logic       error_event;
    logic [7:0] err_q;

    assign error_event = ((state == WAIT_SECOND) && !pick_found && timeout_hit) ||
                         ((state == POLY_WAIT) && poly_done && (poly_polynomial == '0)) ||
                         ((state == OFFS_WAIT) && offs_done && (offs_offset == '0));

    always_ff @(posedge clk_96MHz or negedge reset_n) begin
        if (!reset_n)         err_q <= 8'd0;
        else if (error_event) err_q <= sat_inc(err_q);
    end

    assign error_count = err_q;
`else
    assign error_count = 8'd0;
`endif

endmodule

// File: doc/multi_pulse_identifier.md
Name: multi_pulse_identifier

Overview:
- Parametrised successor of the two-sensor pulse identifier: accepts decoded LFSR words from NUM_SENSORS BMC decoder channels.
- Pairs the first two words from distinct sensors within a timeout window.
- Drives external polynomial_finder / offset_finder through start/done handshakes.
- Publishes a per-sensor pulse ID vector with a valid mask and a ready/ack handshake to the downstream position solver.

Parameters:
- NUM_SENSORS, 4, number of decoder channels (2..16).
- TIMEOUT_TICKS, 100000, clk_96MHz cycles allowed between the first and second capture (~1 ms).
- DATA_W, 17, decoded word / polynomial / offset width.
- TS_W, 24, timestamp width.

Ports:
- clk_96MHz  in  1  system clock.
- reset_n  in  1  asynchronous active-low reset.
- data_available  in  NUM_SENSORS  per-channel decoded-word valid.
- ts_data  in  NUM_SENSORS*TS_W  flattened timestamps; channel i at [i*TS_W +: TS_W].
- decoded_data  in  NUM_SENSORS*DATA_W  flattened decoded words.
- decoder_clear  out  NUM_SENSORS  one-cycle clear pulse to the decoder.
- poly_start  out  1  level request to polynomial finder.
- poly_first_data, poly_second_data  out  DATA_W  captured words.
- poly_first_ts, poly_second_ts  out  TS_W  captured timestamps.
- poly_done  in  1  finder result valid.
- poly_polynomial  in  DATA_W  0 = not found.
- poly_iteration  in  DATA_W  LFSR steps from first to second word.
- offs_start  out  1  level request to offset finder; its data input is poly_first_data.
- offs_done  in  1  finder result valid.
- offs_offset  in  DATA_W  0 = not found.
- polynomial  out  DATA_W  latched polynomial.
- pulse_id  out  NUM_SENSORS*DATA_W  per-sensor pulse ID.
- pulse_valid  out  NUM_SENSORS  sensors carrying a valid ID.
- ready  out  1  result available.
- ack  in  1  consumer accepts result.
- error_count  out  8  only with PULSE_ID_ERRCNT_EN.

Behaviour:
- Reset (asynchronous, reset_n=0):
  - All outputs 0; state IDLE; timer 0.
  - A reset mid-operation abandons everything; no clear pulses are issued.
- IDLE:
  - Arbiter picks the lowest-index channel with data_available=1.
  - On that edge: latch word and timestamp as first, record first_ch, set decoder_clear[first_ch]=1 for exactly one cycle, timer<=0, go to WAIT_SECOND.
- WAIT_SECOND:
  - Timer increments every cycle.
  - Eligible channels: data_available=1, index != first_ch, decoder_clear bit low.
  - Lowest eligible channel is latched as second: second_ch, one-cycle clear, go to POLY_REQ.
  - Repeats on first_ch are ignored and left pending.
  - If timer reaches TIMEOUT_TICKS-1 with no eligible channel, this is a timeout error: go to FLUSH.
  - If data arrives in the timeout cycle, the data wins.
- POLY_REQ / POLY_WAIT:
  - poly_start=1 from POLY_REQ until the poly_done cycle.
  - Any poly_done seen in the POLY_REQ cycle is ignored (stale).
  - poly_done with poly_polynomial==0 is an error: go to FLUSH.
  - Otherwise latch polynomial and iteration, drop poly_start, go to OFFS_REQ.
- OFFS_REQ / OFFS_WAIT:
  - Same protocol with offs_start/offs_done.
  - offs_offset==0 is an error: go to FLUSH.
  - Otherwise:
    - pulse_id[first_ch] <= offset.
    - pulse_id[second_ch] <= (offset + iteration) mod 2^DATA_W (wrap, no saturation).
    - All other pulse_id slices 0.
    - pulse_valid has only bits first_ch and second_ch set.
    - Go to READY.
- READY:
  - ready=1; pulse_id, pulse_valid and polynomial held stable.
  - New data_available is ignored (left pending).
  - ack=1: ready<=0 on the same edge, go to FLUSH.
  - ack asserted outside READY is ignored.
- FLUSH (one cycle):
  - Clear captures, timer, pulse_id, pulse_valid, polynomial, finder requests.
  - Assert decoder_clear for every channel with data_available=1 except first_ch/second_ch already cleared.
  - Go to IDLE.
- Latency: from second capture to ready = 2 + finder latencies + 2 cycles.
- Simultaneous arrival in IDLE of channels i<j: i is captured first, j is captured as second on the next edge.

Optional Feature:
- PULSE_ID_ERRCNT_EN defined:
  - error_count is an 8-bit saturating counter (holds at 255).
  - Incremented once per timeout, zero-polynomial or zero-offset event.
  - Cleared only by reset_n.
- Undefined: error_count is tied to 0 and the counter logic is absent.

Decomposition:
- Shared package pulse_id_pkg holds:
  - DATA_W / TS_W defaults.
  - State encodings IDLE, WAIT_SECOND, POLY_REQ, POLY_WAIT, OFFS_REQ, OFFS_WAIT, READY, FLUSH.
  - Timer width function (clog2 of TIMEOUT_TICKS).
- One sub-module: channel_arbiter, a combinational lowest-index pick over (data_available & ~mask), producing an index and a found flag.

Test Plan:
- Basic pair:
  - Stimulus: ch1 word 0x0A5A5, then ch3 after 50 cycles; finder returns poly 0x1D258 and iteration 120; offset 3000.
  - Response: pulse_id[1]=3000, pulse_id[3]=3120, pulse_valid=4'b1010, ready=1, and one-cycle clears on ch1 then ch3.
- Timeout:
  - Stimulus: only ch0 fires, with TIMEOUT_TICKS=100.
  - Response: FLUSH at cycle 99, no poly_start, return to IDLE; error_count=1 with PULSE_ID_ERRCNT_EN.
- Simultaneous arrival:
  - Stimulus: ch2 and ch0 assert on the same cycle.
  - Response: first=ch0, second=ch2 on the next edge.
- Wrap:
  - Stimulus: offset 0x1FFF0, iteration 0x20.
  - Response: second sensor pulse_id = 0x00010.
- Finder failure:
  - Stimulus: poly_polynomial=0.
  - Response: no offs_start, ready stays 0, FLUSH clears pending channels.
- Handshake and reset:
  - Result held stable across 10 cycles without ack; ack clears ready on the next edge.
  - reset_n low during POLY_WAIT zeroes all outputs immediately.
